seven_seg_readback: RTL and testbench

- Self-test monitor on the display side of the board. It sits on the time-multiplexed dual-digit seven-segment bus (seg, an) that the hex-to-segment path drives.
- Recovers the two hex digits being displayed, qualifies each by stability, and flags illegal patterns and bus contention.
- Delivers each completed digit pair through a valid/ready handshake to on-chip checking logic.

---
 rtl/seven_seg_readback_if.sv | 22 ++
 rtl/seven_seg_readback.sv | 183 ++++++++++++++++++
 tb/tb_seven_seg_readback.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_readback_if.sv
// Display-side bus (seg/an sampled by the monitor) plus the digit-pair
// valid/ready output channel.
interface seven_seg_readback_if;
    logic [6:0] seg;
    logic [1:0] an;
    logic       out_ready;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic       out_valid;

    // Handshake: a pair transfers on a rising clk edge where out_valid and
    // out_ready are both 1; digit0/digit1 hold steady while out_valid is 1.
    modport master (
        output seg, an, out_ready,
        input  digit0, digit1, out_valid
    );

    modport slave (
        input  seg, an, out_ready,
        output digit0, digit1, out_valid
    );
endinterface

// File: rtl/seven_seg_readback.sv
// Seven-segment readback monitor: recovers the two displayed hex digits,
// qualifies them by stability, and reports bad glyphs, contention and overruns.
module seven_seg_readback #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    seven_seg_readback_if.slave  bus,
    input  logic                 err_clear,
    output logic                 err_pattern,
    output logic                 err_contention,
    output logic                 err_overrun
);

    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

    // Returns {legal, nibble} for an active-low seg[6:0] pattern.
    function automatic logic [4:0] decode_glyph(input logic [6:0] s);
        logic [4:0] r;
        r = 5'b0_0000;
        case (s)
            7'b1000000: r = 5'h10;
            7'b1111001: r = 5'h11;
            7'b0100100: r = 5'h12;
            7'b0110000: r = 5'h13;
            7'b0011001: r = 5'h14;
            7'b0010010: r = 5'h15;
            7'b0000010: r = 5'h16;
            7'b1111000: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0010000: r = 5'h19;
            7'b0001000: r = 5'h1A;
            7'b0000011: r = 5'h1B;
            7'b1000110: r = 5'h1C;
            7'b0100001: r = 5'h1D;
            7'b0000110: r = 5'h1E;
            7'b0001110: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    logic [6:0]       seg_q, seg_d, prev_seg_q, prev_seg_d;
    logic [1:0]       an_q, an_d, prev_an_q, prev_an_d;
    logic             smp_vld_q, smp_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cap0_q, cap0_d, cap1_q, cap1_d;
    logic             flag0_q, flag0_d, flag1_q, flag1_d;
    logic [3:0]       digit0_q, digit0_d, digit1_q, digit1_d;
    logic             out_valid_q, out_valid_d;
    logic             err_pat_q, err_pat_d;
    logic             err_con_q, err_con_d;
    logic             err_ovr_q, err_ovr_d;

    logic             same;
    logic             capture;
    logic             set_pat, set_con, set_ovr;
    logic [4:0]       glyph;

    always_comb begin
        seg_d       = bus.seg;
        an_d        = bus.an;
        smp_vld_d   = 1'b1;
        prev_seg_d  = seg_q;
        prev_an_d   = an_q;
        cnt_d       = cnt_q;
        cap0_d      = cap0_q;
        cap1_d      = cap1_q;
        flag0_d     = flag0_q;
        flag1_d     = flag1_q;
        digit0_d    = digit0_q;
        digit1_d    = digit1_q;
        out_valid_d = out_valid_q;
        capture     = 1'b0;
        set_pat     = 1'b0;
        set_con     = 1'b0;
        set_ovr     = 1'b0;
        same        = (seg_q == prev_seg_q) && (an_q == prev_an_q);
        glyph       = decode_glyph(seg_q);

        // smp_vld_q masks the first registered sample after reset, which
        // still holds reset values rather than anything seen on the pins.
        if (smp_vld_q) begin
            case (an_q)
                2'b10, 2'b01: begin
                    if (same) begin
                        cnt_d = (cnt_q == STABLE) ? cnt_q : cnt_q + 1'b1;
                    end else begin
                        cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    capture = (cnt_d == STABLE) && (!same || (cnt_q != STABLE));
                end
                2'b11: cnt_d = '0;
                default: begin
                    cnt_d   = '0;
                    set_con = 1'b1;
                end
            endcase
        end

        if (flag0_q && flag1_q) begin
            flag0_d = 1'b0;
            flag1_d = 1'b0;
            if (!out_valid_q || bus.out_ready) begin
                digit0_d    = cap0_q;
                digit1_d    = cap1_q;
                out_valid_d = 1'b1;
            end else begin
                set_ovr = 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // A capture on the commit edge starts the next pair rather than being lost.
        if (capture) begin
            if (glyph[4]) begin
                if (an_q == 2'b10) begin
                    cap0_d  = glyph[3:0];
                    flag0_d = 1'b1;
                end else begin
                    cap1_d  = glyph[3:0];
                    flag1_d = 1'b1;
                end
            end else begin
                set_pat = 1'b1;
                if (an_q == 2'b10) flag0_d = 1'b0;
                else               flag1_d = 1'b0;
            end
        end

        err_pat_d = set_pat | (err_pat_q & ~err_clear);
        err_con_d = set_con | (err_con_q & ~err_clear);
        err_ovr_d = set_ovr | (err_ovr_q & ~err_clear);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q       <= '0;
            an_q        <= '0;
            smp_vld_q   <= 1'b0;
            prev_seg_q  <= '0;
            prev_an_q   <= '0;
            cnt_q       <= '0;
            cap0_q      <= '0;
            cap1_q      <= '0;
            flag0_q     <= 1'b0;
            flag1_q     <= 1'b0;
            digit0_q    <= '0;
            digit1_q    <= '0;
            out_valid_q <= 1'b0;
            err_pat_q   <= 1'b0;
            err_con_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            seg_q       <= seg_d;
            an_q        <= an_d;
            smp_vld_q   <= smp_vld_d;
            prev_seg_q  <= prev_seg_d;
            prev_an_q   <= prev_an_d;
            cnt_q       <= cnt_d;
            cap0_q      <= cap0_d;
            cap1_q      <= cap1_d;
            flag0_q     <= flag0_d;
            flag1_q     <= flag1_d;
            digit0_q    <= digit0_d;
            digit1_q    <= digit1_d;
            out_valid_q <= out_valid_d;
            err_pat_q   <= err_pat_d;
            err_con_q   <= err_con_d;
            err_ovr_q   <= err_ovr_d;
        end
    end

    assign bus.digit0     = digit0_q;
    assign bus.digit1     = digit1_q;
    assign bus.out_valid  = out_valid_q;
    assign err_pattern    = err_pat_q;
    assign err_contention = err_con_q;
    assign err_overrun    = err_ovr_q;

endmodule

// File: tb/tb_seven_seg_readback.sv
// Directed bench for seven_seg_readback: stimulus pushes expected digit pairs,
// a separate monitor pops and compares each pair the DUT presents.
module tb_seven_seg_readback;

    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GB = 7'b0000011;
    localparam logic [6:0] GC = 7'b1000110;
    localparam logic [6:0] GD = 7'b0100001;
    localparam logic [6:0] GE = 7'b0000110;
    localparam logic [6:0] GF = 7'b0001110;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic clk;
    logic reset;
    logic err_clear;
    logic err_pattern, err_contention, err_overrun;

    seven_seg_readback_if bus ();

    seven_seg_readback #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus.slave),
        .err_clear      (err_clear),
        .err_pattern    (err_pattern),
        .err_contention (err_contention),
        .err_overrun    (err_overrun)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (timeout)");
        $fatal(1, "timeout");
    end

    // scoreboard
    logic [7:0] exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    logic checked;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: compare once per presented pair
    initial begin
        logic [7:0] e;
        checked = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && bus.out_valid && !checked) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pair_unexpected: got %0h expected none", {bus.digit1, bus.digit0});
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.digit1, bus.digit0} !== e) begin
                        n_fail++;
                        $display("FAIL pair: got %0h expected %0h at %0t", {bus.digit1, bus.digit0}, e, $time);
                    end
                end
                checked = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) checked = 1'b0;
        end
    end

    // driver tasks
    task automatic hold(input logic [6:0] s, input logic [1:0] a, input int n);
        bus.seg = s;
        bus.an  = a;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("valid_drop_after_accept", bus.out_valid, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_digit0"}, bus.digit0, 0);
        chk({tag, "_digit1"}, bus.digit1, 0);
        chk({tag, "_err_pattern"}, err_pattern, 0);
        chk({tag, "_err_contention"}, err_contention, 0);
        chk({tag, "_err_overrun"}, err_overrun, 0);
    endtask

    initial begin
        reset         = 1'b0;
        err_clear     = 1'b0;
        bus.seg       = BLANK;
        bus.an        = 2'b11;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b1;
        hold(BLANK, 2'b11, 2);

        // pair 3/A with latency measured from the first edge A is present
        hold(G3, 2'b10, 6);
        bus.seg = GA;
        bus.an  = 2'b01;
        exp_q.push_back({4'hA, 4'h3});
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("latency_edge%0d", i), bus.out_valid, (i == 6) ? 1 : 0);
        end
        hold(BLANK, 2'b11, 2);
        chk("t1_err_pattern", err_pattern, 0);
        chk("t1_err_contention", err_contention, 0);
        chk("t1_err_overrun", err_overrun, 0);
        chk("t1_valid_held", bus.out_valid, 1);
        accept();

        // 3-cycle hold is too short; 4-cycle holds capture
        hold(G3, 2'b10, 3);
        hold(BLANK, 2'b11, 3);
        hold(G7, 2'b01, 4);
        hold(BLANK, 2'b11, 3);
        chk("short_hold_no_pair", bus.out_valid, 0);
        exp_q.push_back({4'h7, 4'h5});
        hold(G5, 2'b10, 4);
        hold(BLANK, 2'b11, 2);
        chk("four_hold_pair", bus.out_valid, 1);
        accept();

        // illegal glyph on digit1 clears its flag
        hold(BLANK, 2'b01, 5);
        chk("err_pattern_set", err_pattern, 1);
        hold(G1, 2'b10, 4);
        hold(BLANK, 2'b11, 2);
        chk("no_pair_after_bad_digit1", bus.out_valid, 0);
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        chk("err_pattern_cleared", err_pattern, 0);

        // contention, then a legal hold still captures
        hold(G2, 2'b00, 1);
        hold(BLANK, 2'b11, 2);
        chk("err_contention_set", err_contention, 1);
        exp_q.push_back({4'h9, 4'h1});
        hold(G9, 2'b01, 4);
        hold(BLANK, 2'b11, 2);
        chk("pair_after_contention", bus.out_valid, 1);

        // overrun: second pair dropped while first pending
        hold(GC, 2'b10, 4);
        hold(GE, 2'b01, 4);
        hold(BLANK, 2'b11, 2);
        chk("err_overrun_set", err_overrun, 1);
        chk("overrun_valid_held", bus.out_valid, 1);
        chk("overrun_digit0_kept", bus.digit0, 4'h1);
        chk("overrun_digit1_kept", bus.digit1, 4'h9);
        accept();

        // asynchronous reset mid-count with digit0 captured
        hold(GD, 2'b10, 4);
        hold(BLANK, 2'b11, 2);
        hold(GF, 2'b01, 2);
        #3;
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        hold(GF, 2'b01, 4);
        hold(BLANK, 2'b11, 2);
        chk("no_pair_from_prereset_digit0", bus.out_valid, 0);
        exp_q.push_back({4'hF, 4'hB});
        hold(GB, 2'b10, 4);
        hold(BLANK, 2'b11, 2);
        chk("pair_after_reset", bus.out_valid, 1);
        accept();

        hold(BLANK, 2'b11, 3);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
